ifmap_row_feeder: RTL and testbench

Producer-side front end for the PE's IFMap input FIFO. It accepts a raw pixel stream over a valid/ready handshake and writes tagged IFMAP_WIDTH-bit words into the IFMap buffer, one row at a time. Each word carries start-of-row and end-of-row tags. It stalls on buffer full and signals row and frame completion to the top-level controller.

---
 rtl/ifmap_row_feeder.sv | 95 +++++++++
 tb/tb_ifmap_row_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifmap_row_feeder.sv
// ifmap_row_feeder: writes row-tagged pixel words into the IFMap buffer.
// Define IFMAP_FEEDER_PAD_EN to wrap every row in PAD zero words on each side.
module ifmap_row_feeder #(
  parameter int IFMAP_WIDTH  = 18,
  parameter int ROW_LEN_SIZE = 8,
  parameter int ROWS_SIZE    = 8,
  parameter int PAD          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [ROW_LEN_SIZE-1:0] i_row_len,
  input  logic [ROWS_SIZE-1:0]    i_num_rows,
  input  logic                    i_src_valid,
  input  logic [IFMAP_WIDTH-3:0]  i_src_data,
  output logic                    o_src_ready,
  input  logic                    i_buf_full,
  output logic                    o_buf_wen,
  output logic [IFMAP_WIDTH-1:0]  o_buf_din,
  output logic                    o_busy,
  output logic                    o_row_done,
  output logic                    o_done
);
`ifdef IFMAP_FEEDER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  // two spare bits so row_len + 2*PAD never wraps the column counter
  localparam int CW = ROW_LEN_SIZE + 2;
  localparam logic [CW-1:0] P = PAD_EN ? CW'(PAD) : '0;
  typedef enum logic [2:0] {IDLE, PAD_L, DATA, PAD_R, FIN} state_t;
  localparam state_t FIRST = PAD_EN ? PAD_L : DATA;
  state_t                  r_state, w_next;
  logic [ROW_LEN_SIZE-1:0] r_len;
  logic [ROWS_SIZE-1:0]    r_rows, r_row;
  logic [CW-1:0]           r_col, w_len;
  logic                    r_row_done, r_done;
  logic                    w_wr, w_sor, w_eor, w_row_end, w_frame_end;
  logic                    w_last_l, w_last_d, w_last_r;
  logic [IFMAP_WIDTH-3:0]  w_data;
  assign w_len       = CW'(r_len);
  assign w_last_l    = r_col == P - CW'(1);
  assign w_last_d    = r_col == P + w_len - CW'(1);
  assign w_last_r    = r_col == P + P + w_len - CW'(1);
  assign w_wr        = !i_buf_full && (r_state == PAD_L || r_state == PAD_R || (r_state == DATA && i_src_valid));
  assign w_sor       = r_col == '0;
  assign w_eor       = PAD_EN ? (r_state == PAD_R && w_last_r) : (r_state == DATA && w_last_d);
  assign w_row_end   = w_wr && w_eor;
  assign w_frame_end = w_row_end && ({1'b0, r_row} + (ROWS_SIZE+1)'(1) == {1'b0, r_rows});
  assign w_data      = r_state == DATA ? i_src_data : '0;
  assign o_src_ready = r_state == DATA && !i_buf_full;
  assign o_buf_wen   = w_wr;
  assign o_buf_din   = w_wr ? {w_sor, w_eor, w_data} : '0;
  assign o_busy      = r_state != IDLE;
  assign o_row_done  = r_row_done;
  assign o_done      = r_done;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !i_start ? IDLE : (i_row_len == '0 || i_num_rows == '0) ? FIN : FIRST;
      PAD_L:   w_next = (w_wr && w_last_l) ? DATA : PAD_L;
      DATA:    w_next = !(w_wr && w_last_d) ? DATA : PAD_EN ? PAD_R : w_frame_end ? FIN : DATA;
      PAD_R:   w_next = !(w_wr && w_last_r) ? PAD_R : w_frame_end ? FIN : PAD_L;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_rows     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_done <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_row_done <= w_row_end;
      r_done     <= r_state == FIN;
      if (r_state == IDLE && i_start) begin
        r_len  <= i_row_len;
        r_rows <= i_num_rows;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_row_end) begin
        r_col <= '0;
        r_row <= r_row + ROWS_SIZE'(1);
      end else if (w_wr) begin
        r_col <= r_col + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifmap_row_feeder.sv
// tb_ifmap_row_feeder: table-driven and randomized frames checked against a word-stream model.
module tb_ifmap_row_feeder;
  localparam int W  = 18;
  localparam int DW = W - 2;
`ifdef IFMAP_FEEDER_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic          clk = 1'b0, rst = 1'b1;
  logic          i_start = 1'b0, i_src_valid = 1'b0, i_buf_full = 1'b0;
  logic [7:0]    i_row_len = '0, i_num_rows = '0;
  logic [DW-1:0] i_src_data = '0;
  logic          o_src_ready, o_buf_wen, o_busy, o_row_done, o_done;
  logic [W-1:0]  o_buf_din;

  ifmap_row_feeder #(.IFMAP_WIDTH(W), .ROW_LEN_SIZE(8), .ROWS_SIZE(8), .PAD(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_row_len(i_row_len), .i_num_rows(i_num_rows),
    .i_src_valid(i_src_valid), .i_src_data(i_src_data), .o_src_ready(o_src_ready),
    .i_buf_full(i_buf_full), .o_buf_wen(o_buf_wen), .o_buf_din(o_buf_din),
    .o_busy(o_busy), .o_row_done(o_row_done), .o_done(o_done));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, src_idx = 0, viol = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
  bit done_seen = 0, busy_at_done = 0;
  logic [W-1:0]  got[$];
  logic [DW-1:0] src_q[$];
  int eor_cyc[$], rd_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (o_buf_wen) begin
      got.push_back(o_buf_din);
      if (got.size() == 1) first_wr = cyc;
      last_wr = cyc;
      if (o_buf_din[W-2]) eor_cyc.push_back(cyc);
    end
    if (o_src_ready && i_src_valid) src_idx++;
    if ((o_src_ready || o_buf_wen) && i_buf_full) viol++;
    if (o_src_ready && i_src_valid && !o_buf_wen) viol++;
    if (o_row_done) rd_cyc.push_back(cyc);
    if (o_done) begin
      done_seen    = 1;
      done_cyc     = cyc;
      busy_at_done = o_busy;
    end
  end

  task automatic clear_mon();
    got.delete(); eor_cyc.delete(); rd_cyc.delete(); src_q.delete();
    src_idx = 0; viol = 0; done_seen = 0;
  endtask

  task automatic drive_src(int vp, int fp);
    i_src_valid = $urandom_range(99) < vp;
    i_buf_full  = $urandom_range(99) < fp;
    i_src_data  = src_idx < src_q.size() ? src_q[src_idx] : '0;
  endtask

  task automatic run_frame(int len, int rows, int vp, int fp, bit seq, int exp_words, int exp_rd);
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] d;
    int wpr = len + 2 * P;
    clear_mon();
    for (int i = 0; i < len * rows; i++) src_q.push_back(seq ? DW'(i + 1) : DW'($urandom));
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < wpr; c++) begin
        d = (c >= P && c < P + len) ? src_q[r * len + c - P] : '0;
        exp_q.push_back({c == 0, c == wpr - 1, d});
      end
    @(posedge clk); #1;
    i_start = 1; i_row_len = 8'(len); i_num_rows = 8'(rows);
    drive_src(vp, fp);
    @(posedge clk); #1;
    i_start = 0;
    for (int n = 0; !done_seen && n < 4000; n++) begin
      drive_src(vp, fp);
      @(posedge clk); #1;
    end
    i_src_valid = 0; i_buf_full = 0;
    chk("done_seen", 32'(done_seen), 1);
    chk("model_words", exp_q.size(), exp_words);
    chk("word_count", got.size(), exp_words);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk($sformatf("word%0d", i), got[i], exp_q[i]);
    chk("row_done_count", rd_cyc.size(), exp_rd);
    for (int i = 0; i < rd_cyc.size() && i < eor_cyc.size(); i++) chk("row_done_timing", rd_cyc[i] - eor_cyc[i], 1);
    if (exp_words > 0) chk("done_timing", done_cyc - last_wr, 2);
    if (exp_words > 0 && vp == 100 && fp == 0) chk("throughput", last_wr - first_wr, exp_words - 1);
    chk("busy_at_done", 32'(busy_at_done), 0);
    chk("handshake_viol", viol, 0);
    chk("src_consumed", src_idx, len * rows);
  endtask

  typedef struct {
    int len, rows, vp, fp;
    bit seq;
    int exp_words, exp_rd;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{3, 2, 100, 0, 1, 2 * (3 + 2 * P), 2};
    tbl[1] = '{4, 1, 50, 0, 0, 4 + 2 * P, 1};
    tbl[2] = '{2, 1, 100, 0, 1, 2 + 2 * P, 1};
    tbl[3] = '{1, 3, 100, 0, 0, 3 * (1 + 2 * P), 3};
    tbl[4] = '{3, 0, 100, 0, 0, 0, 0};
    tbl[5] = '{3, 2, 100, 40, 1, 2 * (3 + 2 * P), 2};
    for (int i = 6; i < 10; i++) begin
      tbl[i].len  = $urandom_range(12, 1);
      tbl[i].rows = $urandom_range(4, 1);
      tbl[i].vp   = $urandom_range(100, 30);
      tbl[i].fp   = $urandom_range(60, 0);
      tbl[i].seq  = 0;
      tbl[i].exp_words = tbl[i].rows * (tbl[i].len + 2 * P);
      tbl[i].exp_rd    = tbl[i].rows;
    end
    // reset state
    @(negedge clk);
    chk("rst_wen", 32'(o_buf_wen), 0);
    chk("rst_ready", 32'(o_src_ready), 0);
    chk("rst_din", 32'(o_buf_din), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_flags", {o_row_done, o_done}, 0);
    @(posedge clk); #1;
    rst = 0;
    foreach (tbl[i]) run_frame(tbl[i].len, tbl[i].rows, tbl[i].vp, tbl[i].fp, tbl[i].seq, tbl[i].exp_words, tbl[i].exp_rd);
    // zero-length row with start held into the busy cycle
    clear_mon();
    @(posedge clk); #1;
    i_start = 1; i_row_len = 0; i_num_rows = 3;
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_busy", 32'(o_busy), 1);
    chk("zero_done_early", 32'(o_done), 0);
    @(posedge clk); #1;
    i_start = 0;
    @(negedge clk);
    chk("zero_done", 32'(o_done), 1);
    chk("zero_busy_off", 32'(o_busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_pulse", 32'(o_done), 0);
    chk("zero_writes", got.size(), 0);
    // async reset in the middle of a row
    clear_mon();
    @(posedge clk); #1;
    i_start = 1; i_row_len = 5; i_num_rows = 1; i_src_valid = 1; i_src_data = 16'h0005;
    @(posedge clk); #1;
    i_start = 0;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("mid_rst_wen", 32'(o_buf_wen), 0);
    chk("mid_rst_ready", 32'(o_src_ready), 0);
    chk("mid_rst_din", 32'(o_buf_din), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_words", got.size(), 2);
    if (got.size() > 0) chk("mid_rst_sor", 32'(got[0]), {2'b10, 16'h0005});
    @(posedge clk); #1;
    rst = 0; i_src_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", got.size(), 2);
    run_frame(2, 1, 100, 0, 1, 2 + 2 * P, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
